// File: rtl/spi_flash_boot_master.sv
// Boot-time AXI4 initiator for the spi_flash slave port.
// Optionally writes the QSPI-switch register, then reads a contiguous flash region in INCR
// bursts (split at BURST_MAX and at 4 KB boundaries) and streams the beats out.
module spi_flash_boot_master #(
  parameter int unsigned     DW        = 128,
  parameter int unsigned     AW        = 32,
  parameter int unsigned     IDW       = 8,
  parameter logic [IDW-1:0]  TXN_ID    = '0,
  parameter logic [AW-1:0]   CFG_ADDR  = '0,
  parameter int unsigned     BURST_MAX = 16
) (
  input  logic              boot_aclk,
  input  logic              boot_areset,
  // Job control
  input  logic              boot_start,
  input  logic              boot_qspi_en,
  input  logic [AW-1:0]     boot_base_addr,
  input  logic [15:0]       boot_num_beats,
  output logic              boot_busy,
  output logic              boot_done,
  output logic              boot_err,
  // Output stream
  output logic [DW-1:0]     boot_out_data,
  output logic              boot_out_valid,
  input  logic              boot_out_ready,
  output logic              boot_out_last,
  // AXI write address
  output logic [IDW-1:0]    boot_awid,
  output logic [AW-1:0]     boot_awaddr,
  output logic [7:0]        boot_awlen,
  output logic [2:0]        boot_awsize,
  output logic [1:0]        boot_awburst,
  output logic              boot_awlock,
  output logic [3:0]        boot_awcache,
  output logic              boot_awvalid,
  input  logic              boot_awready,
  // AXI write data
  output logic [DW-1:0]     boot_wdata,
  output logic [DW/8-1:0]   boot_wstrb,
  output logic              boot_wlast,
  output logic              boot_wvalid,
  input  logic              boot_wready,
  // AXI write response
  input  logic [IDW-1:0]    boot_bid,
  input  logic [1:0]        boot_bresp,
  input  logic              boot_bvalid,
  output logic              boot_bready,
  // AXI read address
  output logic [IDW-1:0]    boot_arid,
  output logic [AW-1:0]     boot_araddr,
  output logic [7:0]        boot_arlen,
  output logic [2:0]        boot_arsize,
  output logic [1:0]        boot_arburst,
  output logic              boot_arlock,
  output logic [3:0]        boot_arcache,
  output logic              boot_arvalid,
  input  logic              boot_arready,
  // AXI read data
  input  logic [IDW-1:0]    boot_rid,
  input  logic [DW-1:0]     boot_rdata,
  input  logic [1:0]        boot_rresp,
  input  logic              boot_rlast,
  input  logic              boot_rvalid,
  output logic              boot_rready
);

  localparam int unsigned NB       = DW / 8;
  localparam int unsigned LSB      = $clog2(NB);
  localparam int unsigned BEATS_4K = 4096 / NB;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CFG_AW  = 3'd1;
  localparam logic [2:0] S_CFG_W   = 3'd2;
  localparam logic [2:0] S_CFG_B   = 3'd3;
  localparam logic [2:0] S_RD_AR   = 3'd4;
  localparam logic [2:0] S_RD_DATA = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // Config write payload: value 0x01 in the top byte lane only.
  localparam logic [DW-1:0] CFG_WDATA = {8'h01, {(DW-8){1'b0}}};
  localparam logic [NB-1:0] CFG_WSTRB = {1'b1, {(NB-1){1'b0}}};

  logic [2:0]    r_state;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_remaining;
  logic [8:0]    r_len;
  logic [8:0]    r_cnt;
  logic          r_err;

  logic [12:0]   w_bnd_beats;
  logic [16:0]   w_len_full;
  logic [8:0]    w_len;
  logic          w_in_aw;
  logic          w_in_w;
  logic          w_in_ar;
  logic          w_in_rd;
  logic          w_r_hs;
  logic          w_cnt_last;
  logic          w_beat_err;
  logic          w_err_now;
  logic [15:0]   w_rem_next;
  logic          w_unused;

  // Burst length: smallest of beats remaining, BURST_MAX and beats left in the current 4 KB page.
  always_comb begin
    w_bnd_beats = 13'(BEATS_4K) - 13'(r_addr[11:LSB]);
    w_len_full  = {1'b0, r_remaining};
    if (w_len_full > 17'(BURST_MAX)) begin
      w_len_full = 17'(BURST_MAX);
    end
    if (w_len_full > 17'(w_bnd_beats)) begin
      w_len_full = 17'(w_bnd_beats);
    end
    w_len = w_len_full[8:0];
  end

  assign w_in_aw = (r_state == S_CFG_AW);
  assign w_in_w  = (r_state == S_CFG_W);
  assign w_in_ar = (r_state == S_RD_AR);
  assign w_in_rd = (r_state == S_RD_DATA);

  // Per-beat bookkeeping; the beat counter, not rlast, decides where a burst ends.
  assign w_r_hs     = w_in_rd & boot_rvalid & boot_out_ready;
  assign w_cnt_last = (r_cnt == 9'd1);
  assign w_beat_err = (boot_rresp != 2'b00) | (boot_rlast != w_cnt_last);
  assign w_err_now  = r_err | w_beat_err;
  assign w_rem_next = r_remaining - 16'(r_len);

  // Job sequencer and datapath registers.
  always_ff @(posedge boot_aclk) begin
    if (boot_areset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (boot_start) begin
            r_addr      <= boot_base_addr;
            r_remaining <= boot_num_beats;
            r_err       <= 1'b0;
            if (boot_qspi_en) begin
              r_state <= S_CFG_AW;
            end else if (boot_num_beats != 16'd0) begin
              r_state <= S_RD_AR;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_CFG_AW: begin
          if (boot_awready) begin
            r_state <= S_CFG_W;
          end
        end
        S_CFG_W: begin
          if (boot_wready) begin
            r_state <= S_CFG_B;
          end
        end
        S_CFG_B: begin
          if (boot_bvalid) begin
            if (boot_bresp != 2'b00) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else if (r_remaining == 16'd0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_RD_AR;
            end
          end
        end
        S_RD_AR: begin
          if (boot_arready) begin
            r_len   <= w_len;
            r_cnt   <= w_len;
            r_state <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_r_hs) begin
            r_cnt <= r_cnt - 9'd1;
            if (w_beat_err) begin
              r_err <= 1'b1;
            end
            if (w_cnt_last) begin
              r_addr      <= r_addr + (AW'(r_len) << LSB);
              r_remaining <= w_rem_next;
              // Errors only take effect at a burst boundary.
              if ((w_rem_next == 16'd0) || w_err_now) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_RD_AR;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Channel outputs decoded from the registered state; payloads are zero outside their phase.
  always_comb begin
    boot_awid      = TXN_ID;
    boot_awvalid   = w_in_aw;
    boot_awaddr    = w_in_aw ? CFG_ADDR : '0;
    boot_awlen     = 8'd0;
    boot_awsize    = w_in_aw ? 3'(LSB) : 3'd0;
    boot_awburst   = w_in_aw ? 2'b01 : 2'b00;
    boot_awlock    = 1'b0;
    boot_awcache   = 4'd0;

    boot_wvalid    = w_in_w;
    boot_wdata     = w_in_w ? CFG_WDATA : '0;
    boot_wstrb     = w_in_w ? CFG_WSTRB : '0;
    boot_wlast     = w_in_w;

    boot_bready    = (r_state == S_CFG_B);

    boot_arid      = TXN_ID;
    boot_arvalid   = w_in_ar;
    boot_araddr    = w_in_ar ? r_addr : '0;
    boot_arlen     = w_in_ar ? 8'(w_len - 9'd1) : 8'd0;
    boot_arsize    = w_in_ar ? 3'(LSB) : 3'd0;
    boot_arburst   = w_in_ar ? 2'b01 : 2'b00;
    boot_arlock    = 1'b0;
    boot_arcache   = 4'd0;

    boot_rready    = w_in_rd & boot_out_ready;
    boot_out_valid = w_in_rd & boot_rvalid;
    boot_out_data  = w_in_rd ? boot_rdata : '0;
    // Final beat of the job: last beat of a burst that ends the job, by count or by error.
    boot_out_last  = w_in_rd & boot_rvalid & w_cnt_last & ((w_rem_next == 16'd0) | w_err_now);

    boot_busy      = (r_state != S_IDLE);
    boot_done      = (r_state == S_DONE);
    boot_err       = r_err;
  end

  assign w_unused = ^{boot_bid, boot_rid, w_len_full[16:9]};

endmodule
